// File: rtl/freq_word_loader.sv
// Serial programming master: takes a parallel frequency word on a valid/ready
// handshake and shifts it MSB first over an sclk/sdata/en three-wire link.
module freq_word_loader #(
  parameter int WIDTH   = 9,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             valid,
  output logic             ready,
  output logic             sclk,
  output logic             sdata,
  output logic             en,
  output logic             done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    TRAIL = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [BIT_W-1:0]   bit_reg, bit_next;
  logic               sclk_reg, sclk_next;
  logic               sdata_reg, sdata_next;
  logic               en_reg, en_next;
  logic               done_reg, done_next;
  logic               tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      div_reg   <= '0;
      bit_reg   <= '0;
      sclk_reg  <= 1'b0;
      sdata_reg <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      sclk_reg  <= sclk_next;
      sdata_reg <= sdata_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
    end
  end

  // Each phase lasts CLK_DIV cycles: the divider is loaded with CLK_DIV-1 on
  // every state change and the phase ends on the cycle it reads zero.
  assign tick = (div_reg == '0);

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    sclk_next  = sclk_reg;
    sdata_next = sdata_reg;
    en_next    = en_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (valid) begin
          state_next = LEAD;
          shift_next = word_in;
          bit_next   = '0;
          div_next   = DIV_LOAD;
          en_next    = 1'b1;
          sclk_next  = 1'b0;
          sdata_next = word_in[WIDTH-1];
        end
      end
      LEAD: begin
        if (tick) begin
          state_next = HI;
          sclk_next  = 1'b1;
          div_next   = DIV_LOAD;
        end else begin
          div_next = div_reg - DIV_W'(1);
        end
      end
      HI: begin
        if (tick) begin
          sclk_next = 1'b0;
          div_next  = DIV_LOAD;
          if (bit_reg < LAST_BIT) begin
            // New bit goes out on the falling sclk edge, a full half-period
            // ahead of the receiver's next sampling edge.
            state_next = LO;
            bit_next   = bit_reg + BIT_W'(1);
            shift_next = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
            sdata_next = shift_reg[WIDTH-2];
          end else begin
            state_next = TRAIL;
          end
        end else begin
          div_next = div_reg - DIV_W'(1);
        end
      end
      LO: begin
        if (tick) begin
          state_next = HI;
          sclk_next  = 1'b1;
          div_next   = DIV_LOAD;
        end else begin
          div_next = div_reg - DIV_W'(1);
        end
      end
      TRAIL: begin
        if (tick) begin
          state_next = IDLE;
          div_next   = DIV_LOAD;
          en_next    = 1'b0;
          sdata_next = 1'b0;
          done_next  = 1'b1;
        end else begin
          div_next = div_reg - DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        en_next    = 1'b0;
        sclk_next  = 1'b0;
        sdata_next = 1'b0;
      end
    endcase
  end

  assign ready = (state_reg == IDLE);
  assign sclk  = sclk_reg;
  assign sdata = sdata_reg;
  assign en    = en_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_freq_word_loader.sv
// Randomised self-checking bench for freq_word_loader: two instances
// (CLK_DIV=2 and CLK_DIV=1) compared cycle by cycle against a timing model.
module tb_freq_word_loader;

  localparam int W = 9;

  typedef struct packed {
    logic en;
    logic sclk;
    logic sdata;
    logic done;
    logic ready;
  } obs_t;

  localparam obs_t IDLE_OBS = 5'b00001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_word = '0, b_word = '0;
  logic         a_valid = 1'b0, b_valid = 1'b0;
  logic         a_ready, a_sclk, a_sdata, a_en, a_done;
  logic         b_ready, b_sclk, b_sdata, b_en, b_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  freq_word_loader #(.WIDTH(W), .CLK_DIV(2)) u_a (
    .clk(clk), .rst(rst), .word_in(a_word), .valid(a_valid),
    .ready(a_ready), .sclk(a_sclk), .sdata(a_sdata), .en(a_en), .done(a_done)
  );

  freq_word_loader #(.WIDTH(W), .CLK_DIV(1)) u_b (
    .clk(clk), .rst(rst), .word_in(b_word), .valid(b_valid),
    .ready(b_ready), .sclk(b_sclk), .sdata(b_sdata), .en(b_en), .done(b_done)
  );

  // Expected outputs t cycles after the handshake edge, from the frame timing
  // rules: k-th sclk rise at (2k-1)*d, bit k held from (2k-2)*d, frame (2W+1)*d.
  function automatic obs_t model(input int d, input logic [W-1:0] w, input int t);
    obs_t m;
    int f;
    int k;
    m = '0;
    f = (2 * W + 1) * d;
    k = t / (2 * d) + 1;
    if (k > W) k = W;
    m.en    = (t < f);
    m.ready = (t >= f);
    m.done  = (t == f);
    m.sclk  = (t < f) && (((t / d) % 2) == 1);
    m.sdata = (t < f) ? w[W-k] : 1'b0;
    return m;
  endfunction

  function automatic obs_t observe(input int sel);
    if (sel == 0) return {a_en, a_sclk, a_sdata, a_done, a_ready};
    return {b_en, b_sclk, b_sdata, b_done, b_ready};
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [W-1:0] w);
    if (sel == 0) begin a_valid = v; a_word = w; end
    else begin b_valid = v; b_word = w; end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = observe(s);
      vectors++;
      if (o !== IDLE_OBS) begin
        miscompares++;
        $display("FAIL reset_hold sel=%0d got=%b want=%b", s, o, IDLE_OBS);
      end
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        o = observe(s);
        vectors++;
        if (o !== IDLE_OBS) begin
          miscompares++;
          $display("FAIL reset_release sel=%0d got=%b want=%b", s, o, IDLE_OBS);
        end
      end
    end
    $display("reset: checked idle outputs during and after reset");
  endtask

  task automatic test_frame(input int sel, input logic [W-1:0] w, input string tag);
    obs_t o, e;
    int d, f, rises;
    logic [W-1:0] cap;
    logic prev_sclk;
    d = (sel == 0) ? 2 : 1;
    f = (2 * W + 1) * d;
    rises = 0; cap = '0; prev_sclk = 1'b0;
    @(negedge clk);
    set_in(sel, 1'b1, w);
    @(posedge clk);
    for (int t = 0; t <= f + 2; t++) begin
      @(negedge clk);
      if (t == 0) set_in(sel, 1'b0, W'($urandom));
      o = observe(sel);
      e = model(d, w, t);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s t=%0d got en/sclk/sdata/done/ready=%b want=%b", tag, t, o, e);
      end
      if (o.sclk && !prev_sclk) begin
        rises++;
        cap = {cap[W-2:0], o.sdata};
      end
      prev_sclk = o.sclk;
    end
    vectors++;
    if (cap !== w || rises != W) begin
      miscompares++;
      $display("FAIL %s_capture got=%h rises=%0d want=%h rises=%0d", tag, cap, rises, w, W);
    end
    $display("%s: sel=%0d word=%h captured=%h rises=%0d", tag, sel, w, cap, rises);
  endtask

  task automatic test_busy_ignore();
    obs_t o, e;
    int f;
    logic [W-1:0] w;
    w = 9'h1A5;
    f = (2 * W + 1) * 2;
    @(negedge clk);
    set_in(0, 1'b1, w);
    @(posedge clk);
    for (int t = 0; t <= f + 4; t++) begin
      @(negedge clk);
      if (t == 0) set_in(0, 1'b0, w);
      if (t == 3) set_in(0, 1'b1, 9'h0FF);
      if (t == f - 3) set_in(0, 1'b0, 9'h0FF);
      o = observe(0);
      e = model(2, w, t);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL busy_ignore t=%0d got=%b want=%b", t, o, e);
      end
    end
    $display("busy_ignore: word=%h with 0FF driven while busy", w);
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int f;
    logic [W-1:0] w1, w2, cap1, cap2;
    logic prev_sclk;
    w1 = 9'h100; w2 = 9'h001;
    f = (2 * W + 1) * 2;
    cap1 = '0; cap2 = '0; prev_sclk = 1'b0;
    @(negedge clk);
    set_in(0, 1'b1, w1);
    @(posedge clk);
    for (int t = 0; t <= f; t++) begin
      @(negedge clk);
      o = observe(0);
      e = model(2, w1, t);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_first t=%0d got=%b want=%b", t, o, e);
      end
      if (o.sclk && !prev_sclk) cap1 = {cap1[W-2:0], o.sdata};
      prev_sclk = o.sclk;
      if (t == f) set_in(0, 1'b1, w2);
    end
    for (int t = 0; t <= f + 2; t++) begin
      @(negedge clk);
      if (t == 0) set_in(0, 1'b0, 9'h155);
      o = observe(0);
      e = model(2, w2, t);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL b2b_second t=%0d got=%b want=%b", t, o, e);
      end
      if (o.sclk && !prev_sclk) cap2 = {cap2[W-2:0], o.sdata};
      prev_sclk = o.sclk;
    end
    vectors++;
    if (cap1 !== w1 || cap2 !== w2) begin
      miscompares++;
      $display("FAIL b2b_capture got=%h,%h want=%h,%h", cap1, cap2, w1, w2);
    end
    $display("back_to_back: words=%h,%h captured=%h,%h", w1, w2, cap1, cap2);
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    logic [W-1:0] w;
    w = W'($urandom);
    @(negedge clk);
    set_in(0, 1'b1, w);
    @(posedge clk);
    // 4th sclk rise lands on edge 14 with CLK_DIV=2
    for (int t = 0; t <= 15; t++) begin
      @(negedge clk);
      if (t == 0) set_in(0, 1'b0, w);
      o = observe(0);
      e = model(2, w, t);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL mid_reset_pre t=%0d got=%b want=%b", t, o, e);
      end
    end
    #1 rst = 1'b1;
    #1;
    o = observe(0);
    vectors++;
    if (o !== IDLE_OBS) begin
      miscompares++;
      $display("FAIL mid_reset_async got=%b want=%b", o, IDLE_OBS);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      o = observe(0);
      vectors++;
      if (o !== IDLE_OBS) begin
        miscompares++;
        $display("FAIL mid_reset_after got=%b want=%b", o, IDLE_OBS);
      end
    end
    $display("mid_reset: aborted word=%h after 4th sclk rise", w);
    test_frame(0, 9'h0AA, "post_reset");
  endtask

  task automatic test_random();
    int sel;
    for (int i = 0; i < 6; i++) begin
      sel = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_frame(sel, W'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_frame(0, 9'h1A5, "single");
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_frame(1, 9'h1FF, "clkdiv1");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_word_loader.md
# freq_word_loader

Serial programming master that takes a parallel fractional frequency word and shifts it out MSB first on an `sclk`/`sdata`/`en` three-wire link. It sits directly upstream of the divider/DSM stage's serial shift register, which samples `sdata` on rising `sclk` while `en` is high. It lets the system controller retune the PLL with a single valid/ready handshake instead of bit-banging the link.

## Interface
Parameters:
- `WIDTH`, default 9: frequency word width. Legal range ≥ 2.
- `CLK_DIV`, default 2: length of one `sclk` half-period, in `clk` cycles. Legal range ≥ 1.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `word_in`  in  WIDTH  frequency word. Sampled only at handshake.
- `valid`  in  1  request to send `word_in`.
- `ready`  out  1  block is idle and can accept a word. Decoded as state == IDLE.
- `sclk`  out  1  serial clock, registered. Idles low.
- `sdata`  out  1  serial data, registered. Changes only while `sclk` is low.
- `en`  out  1  frame enable, registered. High for the whole frame.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- Handshake: a word is accepted on a rising `clk` edge where `valid` and `ready` are both 1. On that edge `word_in` is copied into an internal shift register.
- `valid` is ignored while `ready` is 0. The captured word is then unaffected by `word_in` or `valid`.
- States and transitions:
  - IDLE: `sclk`=0, `en`=0, `sdata`=0. On handshake go to LEAD. On that edge set `en`=1 and `sdata`=word[WIDTH-1].
  - LEAD: `sclk` stays low for CLK_DIV cycles, then go to HI.
  - HI: `sclk`=1 for CLK_DIV cycles; the receiver samples on this rising edge. When it expires:
    - if the bit counter < WIDTH-1, go to LO and present the next lower bit on `sdata` on the same edge;
    - otherwise go to TRAIL.
  - LO: `sclk`=0 for CLK_DIV cycles, then go to HI.
  - TRAIL: `sclk`=0 and `sdata` holds the LSB for CLK_DIV cycles. Then go to IDLE, with `en`=0, `sdata`=0 and `done`=1 for exactly one cycle.
- Counters:
  - Divider counter: width clog2(CLK_DIV+1). Reloads on every state change.
  - Bit counter: width clog2(WIDTH+1). Increments on each HI→LO transition. Cleared at handshake.
- Bit order is MSB first. Exactly WIDTH rising `sclk` edges occur per frame, and the k-th rising edge carries word[WIDTH-k].

## Timing
- Reset values: `sclk`=0, `sdata`=0, `en`=0, `done`=0, `ready`=1 (state IDLE). Internal shift register and counters are 0.
- Reset asserted mid-frame: all outputs are forced to reset values immediately (asynchronously). No `done` is produced. The partial frame is abandoned.
- Cycle numbering: cycle 0 is the handshake edge.
  - `en` rises at edge 0 and falls at edge (2·WIDTH+1)·CLK_DIV.
  - The first `sclk` rise is at edge CLK_DIV. The k-th rise is at edge (2k−1)·CLK_DIV.
  - `done`=1 and `ready`=1 in the cycle after `en` falls.
- Frame length is (2·WIDTH+1)·CLK_DIV cycles. For defaults: 38 cycles, first `sclk` rise at edge 2.
- Setup and hold: `sdata` is stable for CLK_DIV cycles before and CLK_DIV cycles after every rising `sclk` edge.
- Back-to-back: with `valid` held high, the next handshake happens in the `done` cycle. `en` is therefore low for exactly 1 cycle between frames.

## Test plan
- Reset:
  - Stimulus: assert `rst` with `clk` running.
  - Required: `sclk`=0, `sdata`=0, `en`=0, `done`=0, `ready`=1.
  - Stimulus: release `rst` with no `valid`.
  - Required: all outputs stay unchanged.
- Single frame, defaults:
  - Stimulus: `word_in`=9'h1A5.
  - Required: `sdata` sampled at the 9 rising `sclk` edges reads 1,1,0,1,0,0,1,0,1. `en` is high for 38 cycles. `done` pulses once at cycle 38.
- Busy ignore:
  - Stimulus: during the frame for 9'h1A5, drive `valid`=1 with `word_in`=9'h0FF.
  - Required: the frame still carries 9'h1A5, `ready` is 0 throughout, and no second frame starts unless `valid` is still high at `done`.
- Back-to-back:
  - Stimulus: hold `valid` high, present 9'h100, then 9'h001 at the first frame's `done`.
  - Required: the two frames are separated by exactly 1 cycle of `en`=0, and the receiver captures 9'h100 then 9'h001.
- Mid-frame reset:
  - Stimulus: assert `rst` after the 4th rising `sclk` edge.
  - Required: `en`, `sclk` and `sdata` drop to 0 without waiting for `clk`, and there is no `done`. The next frame, 9'h0AA, is sent as a complete 9-bit frame.
- CLK_DIV=1 corner:
  - Stimulus: `word_in`=9'h1FF.
  - Required: frame is 19 cycles, `sclk` toggles every cycle, `sdata`=1 at all 9 rising edges, and `done` is at cycle 19.
